spi_cfg_master: RTL and testbench

Parametrised SPI master for configuring the ADC front-end and neighbouring peripherals (PLL, attenuators) over a shared SCK/MOSI/MISO bus with per-device chip selects. It replaces fixed 24-bit, clock-gated, write-only configuration ports with a registered-SCK engine that offers:
- programmable word width and SCK divider;
- all four SPI modes;
- chip-select setup, hold and gap timing;
- readback on MISO;
- a busy/done handshake.

It sits between the configuration sequencer (ROM/register-driven) and the board pins.

---
 rtl/spi_cfg_pkg.sv | 24 ++
 rtl/spi_clk_div.sv | 53 +++++
 rtl/spi_cfg_master.sv | 167 ++++++++++++++++
 tb/tb_spi_cfg_master.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared types for the SPI configuration master.
// FSM states, {CPOL,CPHA} mode codes and the cs_sel width helper.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  typedef logic [1:0] spi_mode_t;

  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

  function automatic int cs_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCK half-period divider with registered SCK level.
// Strobes fire in the cycle before SCK toggles, tagged lead/trail.
module spi_clk_div #(
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic lead_stb,
  output logic trail_stb,
  output logic sck
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  assign tick      = en && (cnt_q == '0);
  assign lead_stb  = tick && (sck_q == CPOL);
  assign trail_stb = tick && (sck_q != CPOL);
  assign sck       = sck_q;

  // Count down each enabled cycle; toggle SCK when the count expires.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (clr) begin
      cnt_d = '0;
      sck_d = CPOL;
    end else if (tick) begin
      cnt_d = CW'(CLK_DIV - 1);
      sck_d = ~sck_q;
    end else if (en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Divider state, synchronous reset to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= CPOL;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: SPI master for ADC/PLL/attenuator configuration.
// Registered SCK, CS setup/hold/gap timing and MISO readback.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int CLK_DIV  = 2,
  parameter int N_CS     = 2,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    send,
  input  logic [cs_w(N_CS)-1:0]   cs_sel,
  input  logic [DATA_W-1:0]       pattern,
  input  logic                    miso,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_CS-1:0]         cs,
  output logic                    sck,
  output logic                    mosi
);

  localparam int EW    = $clog2(2 * DATA_W + 1);
  localparam int SET_T = CS_SETUP * CLK_DIV;
  localparam int HLD_T = (CS_HOLD + 1) * CLK_DIV;
  localparam int GAP_T = 2 * CLK_DIV;
  localparam int TM1   = (SET_T > HLD_T) ? SET_T : HLD_T;
  localparam int TMAX  = (TM1 > GAP_T) ? TM1 : GAP_T;
  localparam int TW    = $clog2(TMAX);

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [EW-1:0]     ecnt_q, ecnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_CS-1:0]   cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic lead, trail, samp, launch;
  logic div_en, div_clr;

  assign div_clr = (state_q == IDLE);
  assign div_en  = ((state_q == SETUP) && (tmr_q == '0))
                || (state_q == SHIFT);
  assign samp    = CPHA ? trail : lead;
  assign launch  = CPHA ? lead : trail;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (div_clr),
    .en        (div_en),
    .lead_stb  (lead),
    .trail_stb (trail),
    .sck       (sck)
  );

  // Phase sequencing plus shift/sample work on each SCK strobe.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ecnt_d  = ecnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (send && (int'(cs_sel) < N_CS)) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          tx_d    = pattern;
          rx_d    = '0;
          ecnt_d  = '0;
          cs_d    = ~(N_CS'(1) << cs_sel);
          mosi_d  = CPHA ? 1'b0 : pattern[DATA_W-1];
          tmr_d   = TW'(SET_T - 1);
        end
      end
      SETUP: begin
        if (tmr_q == '0) state_d = SHIFT;
        else             tmr_d   = tmr_q - 1'b1;
      end
      SHIFT: begin
        if ((lead || trail) && (ecnt_q == EW'(2 * DATA_W - 1))) begin
          state_d = HOLD;
          tmr_d   = TW'(HLD_T - 1);
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          state_d = GAP;
          cs_d    = '1;
          mosi_d  = 1'b0;
          rdata_d = rx_q;
          done_d  = 1'b1;
          tmr_d   = TW'(GAP_T - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (lead || trail) ecnt_d = ecnt_q + 1'b1;
    if (samp) rx_d = {rx_q[DATA_W-2:0], miso};
    if (launch) begin
      mosi_d = CPHA ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
      tx_d   = tx_q << 1;
    end
  end

  // All state and pin registers; reset drops any partial word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      ecnt_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      cs_q    <= '1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ecnt_q  <= ecnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign cs    = cs_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// tb_spi_cfg_master: default-config loopback instance plus four
// 8-bit CLK_DIV=1 instances (one per SPI mode) with slave models.
module tb_spi_cfg_master;
  import spi_cfg_pkg::*;

  typedef struct {
    spi_mode_t  mode;
    logic [7:0] pat;
    logic [7:0] rep;
    logic [7:0] exp_cap;
    logic [7:0] exp_rd;
  } vec_t;

  localparam int A_LAT = 1 + 2 * (1 + 2 * 24 + 1);
  localparam int A_GAP = 2 * 2;
  localparam int M_LAT = 1 + 1 * (1 + 2 * 8 + 1);
  localparam int M_GAP = 2 * 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  logic        a_rst_n, a_send, a_sel;
  logic [23:0] a_pat, a_rdata;
  logic        a_miso, a_busy, a_done, a_sck, a_mosi;
  logic [1:0]  a_cs;
  assign a_miso = a_mosi;

  spi_cfg_master dut_a (
    .clk     (clk),
    .rst_n   (a_rst_n),
    .send    (a_send),
    .cs_sel  (a_sel),
    .pattern (a_pat),
    .miso    (a_miso),
    .busy    (a_busy),
    .done    (a_done),
    .rdata   (a_rdata),
    .cs      (a_cs),
    .sck     (a_sck),
    .mosi    (a_mosi)
  );

  logic [23:0] a_smp = '0;
  int          a_nsmp = 0;
  int          a_ndone = 0;
  always @(posedge a_sck) begin
    a_smp  <= {a_smp[22:0], a_mosi};
    a_nsmp <= a_nsmp + 1;
  end
  always @(posedge clk) if (a_done) a_ndone <= a_ndone + 1;

  logic            m_rst_n;
  logic [3:0]      m_send, m_miso, m_busy, m_done, m_sck, m_mosi;
  logic [3:0][1:0] m_sel;
  logic [3:0][7:0] m_pat, m_rdata;
  logic [3:0][2:0] m_cs;
  logic [7:0]      s_reply [4];

  for (genvar g = 0; g < 4; g++) begin : g_m
    localparam logic [1:0] MD = 2'(g);
    logic [7:0] cap;
    logic       so;
    int         idx;
    logic       pcs = 1'b1;
    logic       psck = MD[1];

    spi_cfg_master #(
      .DATA_W (8),
      .CLK_DIV(1),
      .N_CS   (3),
      .CPOL   (MD[1]),
      .CPHA   (MD[0])
    ) dut_m (
      .clk     (clk),
      .rst_n   (m_rst_n),
      .send    (m_send[g]),
      .cs_sel  (m_sel[g]),
      .pattern (m_pat[g]),
      .miso    (m_miso[g]),
      .busy    (m_busy[g]),
      .done    (m_done[g]),
      .rdata   (m_rdata[g]),
      .cs      (m_cs[g]),
      .sck     (m_sck[g]),
      .mosi    (m_mosi[g])
    );

    always @(m_cs[g][0], m_sck[g]) begin
      if (pcs && !m_cs[g][0]) begin
        cap = '0;
        idx = 7;
        if (!MD[0]) begin
          so  = s_reply[g][7];
          idx = 6;
        end
      end else if (!m_cs[g][0] && (m_sck[g] != psck)) begin
        if ((m_sck[g] != MD[1]) != MD[0]) begin
          cap = {cap[6:0], m_mosi[g]};
        end else if (idx >= 0) begin
          so  = s_reply[g][3'(idx)];
          idx = idx - 1;
        end
      end
      pcs  = m_cs[g][0];
      psck = m_sck[g];
    end
    assign m_miso[g] = so;
  end

  function automatic logic [7:0] cap_of(input int m);
    case (m)
      0:       return g_m[0].cap;
      1:       return g_m[1].cap;
      2:       return g_m[2].cap;
      default: return g_m[3].cap;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic m_xfer(input vec_t v);
    int m, t0, dc, bc;
    logic [1:0] md;
    m  = int'(v.mode);
    md = v.mode;
    s_reply[m] = v.rep;
    chk("m_sck_idle_pre", 32'(m_sck[m]), 32'(md[1]));
    m_pat[m]  = v.pat;
    m_sel[m]  = 2'd0;
    m_send[m] = 1'b1;
    t0 = cyc + 1;
    dc = 0;
    bc = 0;
    for (int i = 0; i < 100 && bc == 0; i++) begin
      @(negedge clk);
      m_send[m] = 1'b0;
      m_pat[m]  = ~v.pat;
      if (cyc == t0) chk("m_cs_low", 32'(m_cs[m]), 32'h6);
      if (m_done[m] && dc == 0) dc = cyc + 1;
      if (dc != 0 && !m_busy[m]) bc = cyc + 1;
    end
    chk("m_done_lat", 32'(dc - t0), 32'(M_LAT));
    chk("m_busy_lat", 32'(bc - t0), 32'(M_LAT + M_GAP));
    chk("m_rdata", 32'(m_rdata[m]), 32'(v.exp_rd));
    chk("m_cap", 32'(cap_of(m)), 32'(v.exp_cap));
    chk("m_sck_idle_post", 32'(m_sck[m]), 32'(md[1]));
    chk("m_cs_idle_post", 32'(m_cs[m]), 32'h7);
  endtask

  task automatic a_wait(input int t0, input logic [1:0] ecs,
                        input bit pulse, output int dc, output int bc,
                        output int nd, output int bad);
    dc = 0;
    bc = 0;
    nd = 0;
    bad = 0;
    for (int i = 0; i < 400 && bc == 0; i++) begin
      @(negedge clk);
      a_send = pulse && ((cyc + 1 == t0 + 10) || (cyc + 1 == t0 + 50));
      a_pat  = 24'($urandom);
      a_sel  = 1'($urandom);
      if (a_done) begin
        nd++;
        if (dc == 0) dc = cyc + 1;
      end else if (a_busy && dc == 0 && a_cs !== ecs) begin
        bad++;
      end
      if (!a_busy) bc = cyc + 1;
    end
  endtask

  vec_t tbl [8];

  initial begin
    int t0, t1, dc, bc, nd, bad, n0, nd0;
    bit ok;
    vec_t rv;

    tbl[0] = '{MODE0, 8'h81, 8'h3C, 8'h81, 8'h3C};
    tbl[1] = '{MODE1, 8'h81, 8'h3C, 8'h81, 8'h3C};
    tbl[2] = '{MODE2, 8'h81, 8'h3C, 8'h81, 8'h3C};
    tbl[3] = '{MODE3, 8'h81, 8'h3C, 8'h81, 8'h3C};
    tbl[4] = '{MODE0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    tbl[5] = '{MODE1, 8'hFF, 8'h00, 8'hFF, 8'h00};
    tbl[6] = '{MODE2, 8'h01, 8'h80, 8'h01, 8'h80};
    tbl[7] = '{MODE3, 8'h80, 8'h01, 8'h80, 8'h01};

    a_rst_n = 1'b0;
    m_rst_n = 1'b0;
    a_send  = 1'b0;
    a_sel   = 1'b0;
    a_pat   = '0;
    m_send  = '0;
    m_sel   = '0;
    m_pat   = '0;
    for (int i = 0; i < 4; i++) s_reply[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_cs", 32'(a_cs), 32'h3);
    chk("rst_sck", 32'(a_sck), 0);
    chk("rst_mosi", 32'(a_mosi), 0);
    chk("rst_rdata", 32'(a_rdata), 0);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] md;
      md = 2'(i);
      chk("m_rst_sck", 32'(m_sck[i]), 32'(md[1]));
      chk("m_rst_cs", 32'(m_cs[i]), 32'h7);
    end
    a_rst_n = 1'b1;
    m_rst_n = 1'b1;
    @(negedge clk);

    a_pat  = 24'hA5C3F0;
    a_sel  = 1'b1;
    a_send = 1'b1;
    t0 = cyc + 1;
    n0 = a_nsmp;
    a_wait(t0, 2'b01, 1'b0, dc, bc, nd, bad);
    chk("a_done_lat", 32'(dc - t0), 32'(A_LAT));
    chk("a_busy_lat", 32'(bc - t0), 32'(A_LAT + A_GAP));
    chk("a_ndone", 32'(nd), 1);
    chk("a_cs_sel1", 32'(bad), 0);
    chk("a_rdata", 32'(a_rdata), 32'hA5C3F0);
    chk("a_nsamples", 32'(a_nsmp - n0), 24);
    chk("a_mosi_bits", 32'(a_smp), 32'hA5C3F0);
    chk("a_sck_idle", 32'(a_sck), 0);

    a_pat  = 24'h3C0FF1;
    a_sel  = 1'b1;
    a_send = 1'b1;
    t0 = cyc + 1;
    a_wait(t0, 2'b01, 1'b1, dc, bc, nd, bad);
    chk("ign_ndone", 32'(nd), 1);
    chk("ign_cs", 32'(bad), 0);
    chk("ign_done_lat", 32'(dc - t0), 32'(A_LAT));
    chk("ign_rdata", 32'(a_rdata), 32'h3C0FF1);

    a_pat  = 24'h00F00F;
    a_sel  = 1'b0;
    a_send = 1'b1;
    t1 = cyc + 1;
    chk("b2b_period", 32'(t1 - t0), 32'(A_LAT + A_GAP));
    a_wait(t1, 2'b10, 1'b0, dc, bc, nd, bad);
    chk("b2b_cs0", 32'(bad), 0);
    chk("b2b_done_lat", 32'(dc - t1), 32'(A_LAT));
    chk("b2b_rdata", 32'(a_rdata), 32'h00F00F);

    a_pat  = 24'h123456;
    a_sel  = 1'b1;
    a_send = 1'b1;
    n0 = a_nsmp;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      a_send = 1'b0;
      if (a_nsmp - n0 >= 11) ok = 1'b1;
    end
    chk("rst_reach_bit10", 32'(ok), 1);
    nd0 = a_ndone;
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    chk("mid_rst_cs", 32'(a_cs), 32'h3);
    chk("mid_rst_sck", 32'(a_sck), 0);
    chk("mid_rst_busy", 32'(a_busy), 0);
    chk("mid_rst_rdata", 32'(a_rdata), 0);
    chk("mid_rst_mosi", 32'(a_mosi), 0);
    repeat (150) @(negedge clk);
    chk("mid_rst_nodone", 32'(a_ndone - nd0), 0);
    chk("mid_rst_idle", 32'(a_busy), 0);

    a_pat  = 24'hFEDCBA;
    a_sel  = 1'b0;
    a_send = 1'b1;
    t0 = cyc + 1;
    a_wait(t0, 2'b10, 1'b0, dc, bc, nd, bad);
    chk("post_rst_lat", 32'(dc - t0), 32'(A_LAT));
    chk("post_rst_rdata", 32'(a_rdata), 32'hFEDCBA);
    chk("post_rst_cs", 32'(bad), 0);

    m_sel[0]  = 2'd3;
    m_pat[0]  = 8'hFF;
    m_send[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      m_send[0] = 1'b0;
      if (m_cs[0] != 3'b111 || m_busy[0] || m_done[0]) bad++;
    end
    chk("drop_quiet", 32'(bad), 0);

    for (int i = 0; i < 8; i++) m_xfer(tbl[i]);

    for (int i = 0; i < 16; i++) begin
      rv.mode    = 2'($urandom_range(0, 3));
      rv.pat     = 8'($urandom);
      rv.rep     = 8'($urandom);
      rv.exp_cap = rv.pat;
      rv.exp_rd  = rv.rep;
      m_xfer(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
